// File: rtl/sap1_pkg.sv
// sap1_pkg: shared constants for the SAP-1 controller-sequencer.
// Contents: opcode encodings, one-hot T-state encodings, control-word bit
//           indices, the idle control word and small decode helpers.
package sap1_pkg;

  // Opcodes (IR upper nibble)
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // One-hot ring-counter states, T1 in the MSB
  localparam logic [5:0] T1 = 6'b100000;
  localparam logic [5:0] T2 = 6'b010000;
  localparam logic [5:0] T3 = 6'b001000;
  localparam logic [5:0] T4 = 6'b000100;
  localparam logic [5:0] T5 = 6'b000010;
  localparam logic [5:0] T6 = 6'b000001;

  // Control-word bit positions {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
  localparam int CW_CP   = 11;
  localparam int CW_EP   = 10;
  localparam int CW_LM_N = 9;
  localparam int CW_CE_N = 8;
  localparam int CW_LI_N = 7;
  localparam int CW_EI_N = 6;
  localparam int CW_LA_N = 5;
  localparam int CW_EA   = 4;
  localparam int CW_SU   = 3;
  localparam int CW_EU   = 2;
  localparam int CW_LB_N = 1;
  localparam int CW_LO_N = 0;

  localparam int CW_WIDTH = 12;

  // Every active-low strobe deasserted, every active-high strobe off
  localparam logic [CW_WIDTH-1:0] CW_IDLE = 12'h3E3;

  // Compact view of the ring counter; TS_BAD covers zero and multi-hot values
  typedef enum logic [2:0] {
    TS_T1,
    TS_T2,
    TS_T3,
    TS_T4,
    TS_T5,
    TS_T6,
    TS_BAD
  } tstate_e;

  function automatic tstate_e decode_t(input logic [5:0] t);
    tstate_e s;
    case (t)
      T1:      s = TS_T1;
      T2:      s = TS_T2;
      T3:      s = TS_T3;
      T4:      s = TS_T4;
      T5:      s = TS_T5;
      T6:      s = TS_T6;
      default: s = TS_BAD;
    endcase
    return s;
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/sap1_cw_decode.sv
// sap1_cw_decode: combinational (t, opcode) -> raw SAP-1 control word.
// Ports: t (one-hot T-state), opcode (IR upper nibble), cw (raw control
//        word, no halt override; non-one-hot t yields the idle word).
module sap1_cw_decode
  import sap1_pkg::*;
(
  input  logic [5:0]          t,
  input  logic [3:0]          opcode,
  output logic [CW_WIDTH-1:0] cw
);

  tstate_e ts;

  always_comb begin
    ts = decode_t(t);
    cw = CW_IDLE;
    case (ts)
      // Fetch: identical for every opcode
      TS_T1: begin
        cw[CW_EP]   = 1'b1;
        cw[CW_LM_N] = 1'b0;
      end
      TS_T2: begin
        cw[CW_CP]   = 1'b1;
      end
      TS_T3: begin
        cw[CW_CE_N] = 1'b0;
        cw[CW_LI_N] = 1'b0;
      end

      // Execute: opcode is only meaningful from T4 on
      TS_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            // IR address field onto the bus, into MAR
            cw[CW_LM_N] = 1'b0;
            cw[CW_EI_N] = 1'b0;
          end
          OP_OUT: begin
            cw[CW_EA]   = 1'b1;
            cw[CW_LO_N] = 1'b0;
          end
          default: ;
        endcase
      end
      TS_T5: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_CE_N] = 1'b0;
            cw[CW_LA_N] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_CE_N] = 1'b0;
            cw[CW_LB_N] = 1'b0;
          end
          default: ;
        endcase
      end
      TS_T6: begin
        case (opcode)
          OP_ADD: begin
            cw[CW_LA_N] = 1'b0;
            cw[CW_EU]   = 1'b1;
          end
          OP_SUB: begin
            cw[CW_LA_N] = 1'b0;
            cw[CW_EU]   = 1'b1;
            cw[CW_SU]   = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;  // TS_BAD: leave the bus quiet
    endcase
  end

endmodule

// File: rtl/sap1_control_sequencer.sv
// sap1_control_sequencer: SAP-1 control word plus supervisory state.
// Ports: clk/res (async active-high), t (one-hot ring), opcode, con
//        (12-bit control word), clk_en, hlt, ill_op, t_err, instr_cnt.
module sap1_control_sequencer
  import sap1_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [5:0]           t,
  input  logic [3:0]           opcode,
  output logic [CW_WIDTH-1:0]  con,
  output logic                 clk_en,
  output logic                 hlt,
  output logic                 ill_op,
  output logic                 t_err,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  logic [CW_WIDTH-1:0]  cw_raw;

  logic                 hlt_q,    hlt_d;
  logic                 clk_en_q, clk_en_d;
  logic                 ill_op_q, ill_op_d;
  logic                 t_err_q,  t_err_d;
  logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;

  logic                 at_t4;
  logic                 at_t6;
  logic                 t_onehot;

  sap1_cw_decode u_decode (
    .t      (t),
    .opcode (opcode),
    .cw     (cw_raw)
  );

  // Once halted the bus must stay quiet even if the external gate leaks clocks
  assign con = hlt_q ? CW_IDLE : cw_raw;

  // Exact compares: a malformed t can never look like T4 or T6
  assign at_t4    = (t == T4);
  assign at_t6    = (t == T6);
  assign t_onehot = (t != 6'b0) && ((t & (t - 6'd1)) == 6'b0);

  always_comb begin
    hlt_d    = hlt_q;
    clk_en_d = clk_en_q;
    ill_op_d = ill_op_q;
    t_err_d  = t_err_q;
    cnt_d    = cnt_q;

    if (at_t4 && (opcode == OP_HLT)) begin
      hlt_d    = 1'b1;
      clk_en_d = 1'b0;
    end

    // Unsupported opcodes execute as NOP; only the flag records them
    if (at_t4 && !is_legal_op(opcode)) begin
      ill_op_d = 1'b1;
    end

    if (!t_onehot) begin
      t_err_d = 1'b1;
    end

    // Uses the registered halt so the counter freezes from the cycle after HLT
    if (at_t6 && !hlt_q) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hlt_q    <= 1'b0;
      clk_en_q <= 1'b1;
      ill_op_q <= 1'b0;
      t_err_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hlt_q    <= hlt_d;
      clk_en_q <= clk_en_d;
      ill_op_q <= ill_op_d;
      t_err_q  <= t_err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hlt       = hlt_q;
  assign clk_en    = clk_en_q;
  assign ill_op    = ill_op_q;
  assign t_err     = t_err_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
module tb_sap1_control_sequencer;

  logic        clk;
  logic        res;
  logic [5:0]  t;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic        clk_en;
  logic        hlt;
  logic        ill_op;
  logic        t_err;
  logic [7:0]  instr_cnt;

  int checks;
  int errors;
  int exp_cnt;

  logic [11:0] sb[$];

  localparam logic [5:0] S1 = 6'b100000;
  localparam logic [5:0] S2 = 6'b010000;
  localparam logic [5:0] S3 = 6'b001000;
  localparam logic [5:0] S4 = 6'b000100;
  localparam logic [5:0] S5 = 6'b000010;
  localparam logic [5:0] S6 = 6'b000001;

  sap1_control_sequencer #(.CNT_WIDTH(8)) dut (
    .clk       (clk),
    .res       (res),
    .t         (t),
    .opcode    (opcode),
    .con       (con),
    .clk_en    (clk_en),
    .hlt       (hlt),
    .ill_op    (ill_op),
    .t_err     (t_err),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one T-state on the negedge, push the expected word, pop and compare
  task automatic cyc(input logic [5:0] tv, input logic [3:0] op,
                     input logic [11:0] exp, input string name);
    logic [11:0] e;
    @(negedge clk);
    t = tv;
    opcode = op;
    sb.push_back(exp);
    #1;
    e = sb.pop_front();
    checks++;
    if (con !== e) begin
      errors++;
      $display("FAIL %s: con=%h expected %h", name, con, e);
    end
  endtask

  // Full instruction, then check the counter after the T6 posedge
  task automatic run_instr(input logic [3:0] op, input logic [11:0] c4,
                           input logic [11:0] c5, input logic [11:0] c6,
                           input string name);
    cyc(S1, op, 12'h5E3, {name, "_t1"});
    cyc(S2, op, 12'hBE3, {name, "_t2"});
    cyc(S3, op, 12'h263, {name, "_t3"});
    cyc(S4, op, c4, {name, "_t4"});
    cyc(S5, op, c5, {name, "_t5"});
    cyc(S6, op, c6, {name, "_t6"});
    @(posedge clk);
    #1;
    exp_cnt = (exp_cnt + 1) % 256;
    checks++;
    if (instr_cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL %s_cnt: instr_cnt=%0d expected %0d", name, instr_cnt, exp_cnt);
    end
  endtask

  task automatic check_flags(input string name, input logic e_hlt, input logic e_clk_en,
                             input logic e_ill, input logic e_terr);
    checks++;
    if ({hlt, clk_en, ill_op, t_err} !== {e_hlt, e_clk_en, e_ill, e_terr}) begin
      errors++;
      $display("FAIL %s: {hlt,clk_en,ill_op,t_err}=%b expected %b", name,
               {hlt, clk_en, ill_op, t_err}, {e_hlt, e_clk_en, e_ill, e_terr});
    end
    checks++;
    if (instr_cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL %s_cnt: instr_cnt=%0d expected %0d", name, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    t = S1;
    opcode = 4'h0;
    exp_cnt = 0;
    #1;
    check_flags("reset_state", 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (con !== 12'h5E3) begin
      errors++;
      $display("FAIL reset_con: con=%h expected 5e3", con);
    end
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic test_lda();
    run_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3, "lda");
  endtask

  task automatic test_add_sub();
    run_instr(4'h1, 12'h1A3, 12'h2E1, 12'h3C7, "add");
    run_instr(4'h2, 12'h1A3, 12'h2E1, 12'h3CF, "sub");
  endtask

  task automatic test_out();
    run_instr(4'hE, 12'h3F2, 12'h3E3, 12'h3E3, "out");
  endtask

  task automatic test_illegal();
    cyc(S1, 4'h7, 12'h5E3, "ill_t1");
    cyc(S2, 4'h7, 12'hBE3, "ill_t2");
    cyc(S3, 4'h7, 12'h263, "ill_t3");
    cyc(S4, 4'h7, 12'h3E3, "ill_t4");
    @(posedge clk);
    #1;
    check_flags("ill_after_t4", 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(S5, 4'h7, 12'h3E3, "ill_t5");
    cyc(S6, 4'h7, 12'h3E3, "ill_t6");
    @(posedge clk);
    #1;
    exp_cnt++;
    check_flags("ill_counted", 1'b0, 1'b1, 1'b1, 1'b0);
    // Stays set across a following legal instruction
    run_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3, "ill_then_lda");
    check_flags("ill_sticky", 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_t_err();
    cyc(6'b110000, 4'h0, 12'h3E3, "terr_multi_con");
    @(posedge clk);
    #1;
    check_flags("terr_multi", 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(6'b000000, 4'h1, 12'h3E3, "terr_zero_con");
    @(posedge clk);
    #1;
    check_flags("terr_zero", 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(6'b000011, 4'h1, 12'h3E3, "terr_t56_con");
    @(posedge clk);
    #1;
    check_flags("terr_t56_nocount", 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_hlt();
    cyc(S1, 4'hF, 12'h5E3, "hlt_t1");
    cyc(S2, 4'hF, 12'hBE3, "hlt_t2");
    cyc(S3, 4'hF, 12'h263, "hlt_t3");
    cyc(S4, 4'hF, 12'h3E3, "hlt_t4");
    @(posedge clk);
    #1;
    check_flags("hlt_latched", 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(S5, 4'hF, 12'h3E3, "hlt_t5");
    cyc(S6, 4'hF, 12'h3E3, "hlt_t6");
    @(posedge clk);
    #1;
    check_flags("hlt_frozen", 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(S1, 4'h0, 12'h3E3, "hlt_next_t1");
    cyc(S4, 4'h0, 12'h3E3, "hlt_next_t4");
    res = 1'b1;
    #1;
    exp_cnt = 0;
    check_flags("hlt_res_pulse", 1'b0, 1'b1, 1'b0, 1'b0);
    t = S1;
    res = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 255; i++) begin
      run_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3, "wrap_run");
    end
    checks++;
    if (instr_cnt !== 8'd255) begin
      errors++;
      $display("FAIL wrap_255: instr_cnt=%0d expected 255", instr_cnt);
    end
    run_instr(4'h1, 12'h1A3, 12'h2E1, 12'h3C7, "wrap_last");
    checks++;
    if (instr_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0: instr_cnt=%0d expected 0", instr_cnt);
    end
  endtask

  task automatic test_async_reset();
    run_instr(4'h2, 12'h1A3, 12'h2E1, 12'h3CF, "ar_pre");
    cyc(6'b000000, 4'h0, 12'h3E3, "ar_bad_t");
    cyc(S1, 4'h9, 12'h5E3, "ar_t1");
    cyc(S2, 4'h9, 12'hBE3, "ar_t2");
    cyc(S3, 4'h9, 12'h263, "ar_t3");
    cyc(S4, 4'h9, 12'h3E3, "ar_t4");
    cyc(S5, 4'h9, 12'h3E3, "ar_t5");
    check_flags("ar_before", 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    res = 1'b1;
    #1;
    exp_cnt = 0;
    check_flags("ar_mid_t5", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    t = S1;
    opcode = 4'h0;
    res = 1'b0;
    #1;
    checks++;
    if (con !== 12'h5E3) begin
      errors++;
      $display("FAIL ar_back_t1: con=%h expected 5e3", con);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 0;
    test_reset();
    test_lda();
    test_add_sub();
    test_out();
    test_illegal();
    test_t_err();
    test_hlt();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap1_control_sequencer.md
Name: sap1_control_sequencer

Overview:
- Controller-sequencer stage that consumes the 6-bit one-hot T-state ring (`t`, T1=6'b100000 … T6=6'b000001) and the instruction-register opcode.
- Produces the 12-bit SAP-1 control word that drives PC, MAR, RAM, IR, A, ALU, B and OUT.
- Holds the sequential supervisory state: halt latch, clock-enable, sticky error flags and a retired-instruction counter.

Parameters:
- CNT_WIDTH, 8, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; `t` changes on negedge, this block samples on posedge.
- res  input  1  asynchronous, active-high reset.
- t  input  6  one-hot T-state from the ring counter.
- opcode  input  4  IR upper nibble; valid from T4 onward.
- con  output  12  control word {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}, bit 11 down to bit 0.
- clk_en  output  1  clock enable to the external clock gate; 0 once halted.
- hlt  output  1  halt latched.
- ill_op  output  1  sticky: unsupported opcode seen at T4.
- t_err  output  1  sticky: `t` not one-hot at a posedge.
- instr_cnt  output  CNT_WIDTH  instructions retired.

Behaviour:
- Reset (async, res=1): hlt=0, clk_en=1, ill_op=0, t_err=0, instr_cnt=0. `con` is combinational, so with `t`=T1 it reads 12'h5E3.
- Idle word CW_IDLE=12'h3E3: all active-low bits 1, all active-high bits 0.
- `con` is a zero-latency combinational function of (`t`, `opcode`, `hlt`). When hlt=1, con=CW_IDLE regardless of `t`.
- Fetch, any opcode:
  - T1: Ep, Lm_n=0 → 12'h5E3.
  - T2: Cp → 12'hBE3.
  - T3: CE_n=0, Li_n=0 → 12'h263.
- Execute, starting from CW_IDLE:
  - LDA 4'h0: T4 Lm_n,Ei_n=0 (12'h1A3); T5 CE_n,La_n=0 (12'h2C3); T6 idle.
  - ADD 4'h1: T4 as LDA; T5 CE_n,Lb_n=0 (12'h2E1); T6 La_n=0, Eu=1 (12'h3C7).
  - SUB 4'h2: as ADD, except T6 also Su=1 (12'h3CF).
  - OUT 4'hE: T4 Ea=1, Lo_n=0 (12'h3F2); T5/T6 idle.
  - HLT 4'hF: T4–T6 idle.
  - Any other opcode: T4–T6 idle (NOP).
- Sequential updates, on posedge clk, when res=0:
  - `t`==T4 and opcode==HLT → hlt←1, clk_en←0. Both are sticky until res.
  - `t`==T4 and opcode not in {0,1,2,E,F} → ill_op←1 (sticky). Execution continues as NOP.
  - `t` is zero or has more than one bit set → t_err←1 (sticky). `con` for a non-one-hot `t` is CW_IDLE.
  - `t`==T6 and hlt==0 → instr_cnt←instr_cnt+1, wrapping 2^CNT_WIDTH−1→0.
- Simultaneous events:
  - HLT at T4 plus illegal opcode cannot coexist, since HLT is legal.
  - t_err and counting are independent: a malformed `t` never increments the counter, because the T6 compare is exact.
  - Once halted, the counter freezes and `con` stays idle even if the clock continues.
- Reset asserted mid-instruction: all state clears immediately (async). `con` follows `t` as soon as the ring counter returns to T1.

Decomposition:
- Package sap1_pkg:
  - opcode constants OP_LDA/OP_ADD/OP_SUB/OP_OUT/OP_HLT;
  - T-state constants T1..T6;
  - control-bit index constants;
  - CW_IDLE.
- Sub-module sap1_cw_decode: purely combinational (`t`, `opcode`) → raw control word.
- Top module: adds the hlt override plus all sequential flags and the counter.

Test Plan:
- Reset, then run LDA (opcode 0) through T1–T6 → `con` = 5E3, BE3, 263, 1A3, 2C3, 3E3; instr_cnt=1 after the T6 posedge.
- SUB (opcode 2) through T4–T6 → `con` = 1A3, 2E1, 3CF.
- OUT at T4 gives `con`=3F2. HLT at T4 gives, after that posedge, hlt=1, clk_en=0 and con=3E3 for T5, T6 and later T1; instr_cnt unchanged; res pulse → hlt=0, clk_en=1.
- Opcode 4'h7 at T4 → ill_op=1 and con=3E3 for T4–T6; instr_cnt still increments; ill_op stays 1 until res.
- `t`=6'b110000 at a posedge → t_err=1 and con=3E3; `t`=0 → t_err=1; instr_cnt unaffected in both cases.
- With CNT_WIDTH=8, run 256 instructions → instr_cnt wraps 255→0. Assert res asynchronously mid-T5 → all flags and instr_cnt are 0 immediately, without waiting for a clock edge.
